// File: rtl/divider.sv
// Sequential 32-bit signed divider: radix-2 restoring division on operand magnitudes,
// followed by a sign-fix cycle. Quotient and remainder follow C truncation rules.
module divider (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        start,
  output logic [31:0] z,
  output logic [31:0] r,
  output logic        dz,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] w_q;
  logic [31:0] absY_q;
  logic [31:0] origX_q;
  logic        sq_q;
  logic        sr_q;
  logic        zero_q;
  logic [31:0] z_q;
  logic [31:0] r_q;
  logic        dz_q;
  logic        busy_q;

  logic [31:0] absX_d;
  logic [31:0] absY_d;
  logic [32:0] diff_d;
  logic [63:0] wStep_d;
  logic [31:0] quot_d;
  logic [31:0] rem_d;

  // Magnitudes wrap naturally, so |0x80000000| stays 0x80000000 as an unsigned value.
  always_comb begin
    absX_d = x[31] ? (32'd0 - x) : x;
    absY_d = y[31] ? (32'd0 - y) : y;
  end

  // One restoring step: trial-subtract the divisor from the shifted partial remainder.
  always_comb begin
    diff_d  = {1'b0, w_q[62:31]} - {1'b0, absY_q};
    wStep_d = {w_q[62:0], 1'b0};
    if (!diff_d[32]) begin
      wStep_d = {diff_d[31:0], w_q[30:0], 1'b1};
    end
  end

  always_comb begin
    quot_d = sq_q ? (32'd0 - w_q[31:0])  : w_q[31:0];
    rem_d  = sr_q ? (32'd0 - w_q[63:32]) : w_q[63:32];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      w_q     <= 64'd0;
      absY_q  <= 32'd0;
      origX_q <= 32'd0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      zero_q  <= 1'b0;
      z_q     <= 32'd0;
      r_q     <= 32'd0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sq_q    <= x[31] ^ y[31];
            sr_q    <= x[31];
            zero_q  <= (y == 32'd0);
            origX_q <= x;
            absY_q  <= absY_d;
            w_q     <= {32'd0, absX_d};
            cnt_q   <= 5'd0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          w_q   <= wStep_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          // A zero divisor reports all-ones quotient and hands the dividend back as remainder.
          if (zero_q) begin
            z_q  <= 32'hFFFF_FFFF;
            r_q  <= origX_q;
            dz_q <= 1'b1;
          end else begin
            z_q  <= quot_d;
            r_q  <= rem_d;
            dz_q <= 1'b0;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign z    = z_q;
  assign r    = r_q;
  assign dz   = dz_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed vector table, handshake/reset sequences,
// and randomized operands against a plain-arithmetic C-semantics model.
module tb_divider;

  logic        clk;
  logic        rst;
  logic [31:0] x;
  logic [31:0] y;
  logic        start;
  logic [31:0] z;
  logic [31:0] r;
  logic        dz;
  logic        busy;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[9];

  divider dut (
    .clk  (clk),
    .rst  (rst),
    .x    (x),
    .y    (y),
    .start(start),
    .z    (z),
    .r    (r),
    .dz   (dz),
    .busy (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // C-style truncating division done with wide signed arithmetic.
  task automatic refDiv(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] qz, output logic [31:0] qr, output logic qdz);
    longint sa;
    longint sb;
    longint q;
    longint m;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      qz  = 32'hFFFF_FFFF;
      qr  = a;
      qdz = 1'b1;
    end else begin
      q   = sa / sb;
      m   = sa % sb;
      qz  = q[31:0];
      qr  = m[31:0];
      qdz = 1'b0;
    end
  endtask

  // Called at a falling edge while idle; returns at the falling edge of the first idle cycle.
  task automatic applyStimulus(input logic [31:0] ax, input logic [31:0] ay, output int busyCycles);
    x     = ax;
    y     = ay;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x     = $urandom;
    y     = $urandom;
    checkOutput("busy_rise", {31'd0, busy}, 32'd1);
    busyCycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      busyCycles++;
    end
  endtask

  initial begin
    int          n;
    logic [31:0] ez;
    logic [31:0] er;
    logic        edz;

    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    start    = 1'b0;
    x        = 32'd0;
    y        = 32'd0;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1] = '{32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
    vecs[2] = '{32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0};
    vecs[3] = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0};
    vecs[4] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[5] = '{32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0};
    vecs[6] = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    vecs[7] = '{32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1};
    vecs[8] = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_z", z, 32'd0);
    checkOutput("reset_r", r, 32'd0);
    checkOutput("reset_dz", {31'd0, dz}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);

    // Start asserted while still in reset must be ignored.
    start = 1'b1;
    x     = 32'd8;
    y     = 32'd2;
    @(posedge clk);
    #1;
    checkOutput("reset_over_start", {31'd0, busy}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].x, vecs[i].y, n);
      checkOutput($sformatf("vec%0d_busy_cycles", i), n, 32'd33);
      checkOutput($sformatf("vec%0d_z", i), z, vecs[i].z);
      checkOutput($sformatf("vec%0d_r", i), r, vecs[i].r);
      checkOutput($sformatf("vec%0d_dz", i), {31'd0, dz}, {31'd0, vecs[i].dz});
    end

    // Second start mid-operation is ignored and outputs hold the previous result.
    x     = 32'd100;
    y     = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n == 5) checkOutput("hold_z_during_run", z, 32'd3);
      if (n == 10) begin
        x     = 32'd1;
        y     = 32'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    checkOutput("ignore_busy_cycles", n, 32'd33);
    checkOutput("ignore_z", z, 32'd14);
    checkOutput("ignore_r", r, 32'd2);

    // Start in the very first idle cycle is accepted; abort it with reset midway.
    x     = 32'd100;
    y     = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("b2b_busy_rise", {31'd0, busy}, 32'd1);
    repeat (16) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_z", z, 32'd0);
    checkOutput("abort_r", r, 32'd0);
    checkOutput("abort_dz", {31'd0, dz}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(32'd50, 32'd5, n);
    checkOutput("post_abort_busy_cycles", n, 32'd33);
    checkOutput("post_abort_z", z, 32'd10);
    checkOutput("post_abort_r", r, 32'd0);

    for (int i = 0; i < 2000; i++) begin
      logic [31:0] ax;
      logic [31:0] ay;
      case ($urandom_range(0, 5))
        0:       begin ax = $urandom; ay = 32'd0; end
        1:       begin ax = $urandom; ay = $urandom_range(1, 20); end
        2:       begin ax = $urandom; ay = 32'd0 - $urandom_range(1, 20); end
        3:       begin ax = 32'h8000_0000; ay = $urandom; end
        default: begin ax = $urandom; ay = $urandom >> $urandom_range(0, 31); end
      endcase
      refDiv(ax, ay, ez, er, edz);
      applyStimulus(ax, ay, n);
      checkOutput($sformatf("rand%0d_busy_cycles", i), n, 32'd33);
      checkOutput($sformatf("rand%0d_z x=%h y=%h", i, ax, ay), z, ez);
      checkOutput($sformatf("rand%0d_r x=%h y=%h", i, ax, ay), r, er);
      checkOutput($sformatf("rand%0d_dz", i), {31'd0, dz}, {31'd0, edz});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
